rat_intr_ctrl: RTL and testbench
================================

Name: rat_intr_ctrl

Overview:
Parametrised interrupt controller for the RAT MCU wrapper, replacing the single hard-wired INTR/BTNC path with NUM_CH debounced button/switch channels. It synchronises and debounces each channel, latches rising edges as pending, applies a CPU-writable mask and drives the MCU INTR line. The MCU acknowledges on INTA and reads status over the existing PORT_ID/IO_STRB I/O bus.

Parameters:
NUM_CH, 4, number of interrupt channels (1..8)
DEB_CYCLES, 4, consecutive stable cycles required to accept a new level (>=1)
HOLDOFF, 2, cycles INTR is forced low after an acknowledge (>=1)
MASK_PORT, 8'h20, port ID for the mask register (read/write)
STAT_PORT, 8'h21, port ID for the pending register (read-only)
CLR_PORT, 8'h22, port ID for write-1-to-clear of pending bits
ID_PORT, 8'h23, port ID for the current vector ID (read-only)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
BTN  in  NUM_CH  raw asynchronous channel inputs
IO_STRB  in  1  MCU output strobe, one cycle per write
PORT_ID  in  8  MCU port address
DATA_IN  in  8  MCU output data
DATA_OUT  out  8  read data for the addressed port, combinational
INTR  out  1  interrupt request to MCU
INTA  in  1  interrupt acknowledge from MCU

Behaviour:
- Reset (RST high at a CLK edge): sync flops, debounced state, counters, pending, mask, CUR_ID and FSM cleared. INTR=0 and FSM=IDLE after that edge. The same applies when reset arrives mid-operation, including during ASSERT.
- Synchroniser: 2 flops per channel. sync2 is the sampled level.
- Debounce (per channel): counter of width $clog2(DEB_CYCLES+1).
  - It increments while sync2 != deb and clears when they are equal.
  - deb toggles on the DEB_CYCLES-th consecutive edge with sync2 != deb. The counter then clears.
- Edge detect: if deb rises (0->1), pending[i] is set on the next edge. Falling edges are ignored.
- Mask write: IO_STRB && PORT_ID==MASK_PORT gives mask <= DATA_IN[NUM_CH-1:0]. Reset mask = 0, so all channels are masked.
- Clear write: IO_STRB && PORT_ID==CLR_PORT gives pending <= pending & ~DATA_IN[NUM_CH-1:0].
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - Masked channels still accumulate pending.
- active = pending & mask.
- FSM states:
  - IDLE: INTR=0. If active!=0, latch CUR_ID = lowest-index set bit of active and go to ASSERT. INTR=1 from the next cycle.
  - ASSERT: INTR=1 and CUR_ID is frozen.
    - If INTA=1: clear pending[CUR_ID] and go to HOLDOFF. If a new edge on that channel coincides, the set wins.
    - Else if active[CUR_ID]==0 (cleared or masked by the CPU): withdraw to IDLE with INTR=0 on the next cycle. If other bits are still active, IDLE re-arbitrates the next cycle.
  - HOLDOFF: INTR=0 for exactly HOLDOFF cycles, then IDLE. Edges arriving here stay pending.
  - INTA outside ASSERT is ignored.
- Latency: BTN rises and is held stable. Counting from the first edge that samples it high, INTR goes high after edge 4+DEB_CYCLES (8 for the defaults).
- DATA_OUT decode (combinational, zero-extended to 8 bits):
  - MASK_PORT returns mask.
  - STAT_PORT returns pending.
  - ID_PORT returns {INTR, 4'b0, CUR_ID[2:0]}.
  - Any other port returns 8'h00.
- A BTN held high through reset release produces one pending edge after debounce.

Test Plan:
1. Default params, write MASK_PORT=8'h0F, pulse BTN[2] high and hold -> INTR=1 exactly 8 cycles after the first sampling edge. ID_PORT reads 8'h82. INTA for 1 cycle -> STAT_PORT reads 8'h00, INTR low for 2 cycles, stays low.
2. Bounce: toggle BTN[0] every 2 cycles for 20 cycles, then hold high -> no pending until 4 stable cycles. Exactly one interrupt results.
3. Priority: BTN[1] and BTN[3] rise on the same cycle with mask=8'h0F -> first CUR_ID=1. After INTA and the 2-cycle holdoff -> second INTR with CUR_ID=3.
4. Mask/withdraw: with mask=8'h00, BTN[0] rises -> STAT_PORT=8'h01, INTR=0. Write mask=8'h01 -> INTR=1 two cycles later. Write CLR_PORT=8'h01 before INTA -> INTR=0 next cycle, FSM IDLE.
5. Set-vs-clear collision: a CLR_PORT=8'h04 write coincides with the pending[2] set edge -> pending[2] remains 1.
6. Reset mid-ASSERT: RST high one cycle while INTR=1 -> INTR=0, mask=0, STAT_PORT=8'h00 after the edge. With BTN[1] still held high and the mask rewritten to 8'h02 -> a new interrupt with CUR_ID=1.

Source files
------------

// File: rtl/rat_intr_ctrl.sv
// Multi-channel interrupt controller for the RAT MCU: per-channel sync + debounce,
// rising-edge pending latch, CPU mask, priority arbitration and INTA/holdoff handshake.
module rat_intr_ctrl #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned HOLDOFF    = 2,
  parameter logic [7:0]  MASK_PORT  = 8'h20,
  parameter logic [7:0]  STAT_PORT  = 8'h21,
  parameter logic [7:0]  CLR_PORT   = 8'h22,
  parameter logic [7:0]  ID_PORT    = 8'h23
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] BTN,
  input  logic              IO_STRB,
  input  logic [7:0]        PORT_ID,
  input  logic [7:0]        DATA_IN,
  output logic [7:0]        DATA_OUT,
  output logic              INTR,
  input  logic              INTA
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned HW = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_HOLDOFF
  } state_t;

  state_t state, state_n;

  logic [NUM_CH-1:0] sync1, sync2;
  logic [NUM_CH-1:0] deb, deb_q;
  logic [DW-1:0]     cnt [NUM_CH];
  logic [NUM_CH-1:0] rise;

  logic [NUM_CH-1:0] pending, mask, active;
  logic [NUM_CH-1:0] clr_vec, ack_clr, cur_bit;
  logic              mask_wr, clr_wr;

  logic [2:0]        cur_id, cur_id_n, lowest;
  logic              found;
  logic [HW-1:0]     hcnt, hcnt_n;

  logic              data_in_unused;
  assign data_in_unused = ^DATA_IN;

  // Synchroniser and debounce: deb only follows sync2 after DEB_CYCLES disagreeing edges
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= BTN;
      sync2 <= sync1;
      deb_q <= deb;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == DW'(DEB_CYCLES - 1)) begin
            deb[i] <= ~deb[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign rise    = deb & ~deb_q;
  assign mask_wr = IO_STRB && (PORT_ID == MASK_PORT);
  assign clr_wr  = IO_STRB && (PORT_ID == CLR_PORT);
  assign clr_vec = clr_wr ? DATA_IN[NUM_CH-1:0] : '0;
  assign active  = pending & mask;

  // New edges are OR'd in after clears so a coincident set always wins
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      if (mask_wr) begin
        mask <= DATA_IN[NUM_CH-1:0];
      end
      pending <= (pending & ~clr_vec & ~ack_clr) | rise;
    end
  end

  always_comb begin
    lowest = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (active[i] && !found) begin
        lowest = 3'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    cur_bit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cur_bit[i] = (cur_id == 3'(i));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      cur_id <= '0;
      hcnt   <= '0;
    end else begin
      state  <= state_n;
      cur_id <= cur_id_n;
      hcnt   <= hcnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cur_id_n = cur_id;
    hcnt_n   = hcnt;
    ack_clr  = '0;
    case (state)
      S_IDLE: begin
        if (active != '0) begin
          cur_id_n = lowest;
          state_n  = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (INTA) begin
          ack_clr = cur_bit;
          hcnt_n  = '0;
          state_n = S_HOLDOFF;
        end else if ((active & cur_bit) == '0) begin
          state_n = S_IDLE;
        end
      end
      S_HOLDOFF: begin
        if (hcnt == HW'(HOLDOFF - 1)) begin
          state_n = S_IDLE;
        end else begin
          hcnt_n = hcnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign INTR = (state == S_ASSERT);

  always_comb begin
    DATA_OUT = '0;
    if (PORT_ID == MASK_PORT) begin
      DATA_OUT[NUM_CH-1:0] = mask;
    end else if (PORT_ID == STAT_PORT) begin
      DATA_OUT[NUM_CH-1:0] = pending;
    end else if (PORT_ID == ID_PORT) begin
      DATA_OUT = {INTR, 4'b0000, cur_id};
    end
  end

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Bench for rat_intr_ctrl: register-decode vector table through a scoreboard queue,
// then hand-written sequences for latency, bounce, priority, mask/withdraw, collision and reset.
module tb_rat_intr_ctrl;

  localparam logic [7:0] MASK_P = 8'h20;
  localparam logic [7:0] STAT_P = 8'h21;
  localparam logic [7:0] CLR_P  = 8'h22;
  localparam logic [7:0] ID_P   = 8'h23;

  logic       clk = 1'b0;
  logic       rst, io_strb, inta, intr;
  logic [3:0] btn;
  logic [7:0] port_id, data_in, data_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       wr;
    logic [7:0] wport;
    logic [7:0] wdata;
    logic [7:0] rport;
    logic [7:0] exp;
  } vec_t;

  vec_t       vt [9];
  logic [7:0] sbq [$];

  always #5 clk = ~clk;

  rat_intr_ctrl #(
    .NUM_CH(4), .DEB_CYCLES(4), .HOLDOFF(2),
    .MASK_PORT(MASK_P), .STAT_PORT(STAT_P), .CLR_PORT(CLR_P), .ID_PORT(ID_P)
  ) dut (
    .CLK(clk), .RST(rst), .BTN(btn), .IO_STRB(io_strb), .PORT_ID(port_id),
    .DATA_IN(data_in), .DATA_OUT(data_out), .INTR(intr), .INTA(inta)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    io_strb = 1'b1;
    port_id = p;
    data_in = d;
    step(1);
    io_strb = 1'b0;
    data_in = 8'h00;
    port_id = 8'h00;
  endtask

  task automatic chk_rd(input string name, input logic [7:0] p, input logic [7:0] exp);
    port_id = p;
    #1;
    check(name, data_out, exp);
  endtask

  task automatic chk_intr(input string name, input logic exp);
    check(name, {7'b0, intr}, {7'b0, exp});
  endtask

  task automatic pulse_inta();
    inta = 1'b1;
    step(1);
    inta = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    vt[0] = '{1'b1, MASK_P, 8'h05, MASK_P, 8'h05};
    vt[1] = '{1'b1, MASK_P, 8'hFF, MASK_P, 8'h0F};
    vt[2] = '{1'b1, MASK_P, 8'hA3, MASK_P, 8'h03};
    vt[3] = '{1'b1, STAT_P, 8'hFF, STAT_P, 8'h00};
    vt[4] = '{1'b1, ID_P,   8'hFF, ID_P,   8'h00};
    vt[5] = '{1'b1, CLR_P,  8'hFF, STAT_P, 8'h00};
    vt[6] = '{1'b0, 8'h00,  8'h00, 8'h24,  8'h00};
    vt[7] = '{1'b0, 8'h00,  8'h00, MASK_P, 8'h03};
    vt[8] = '{1'b1, MASK_P, 8'h00, 8'h00,  8'h00};

    rst = 1'b1; io_strb = 1'b0; inta = 1'b0; btn = '0;
    port_id = 8'h00; data_in = 8'h00;
    step(2);
    rst = 1'b0;
    chk_intr("rst_intr", 1'b0);
    chk_rd("rst_mask", MASK_P, 8'h00);
    chk_rd("rst_stat", STAT_P, 8'h00);
    chk_rd("rst_id", ID_P, 8'h00);

    for (int i = 0; i < 9; i++) begin
      sbq.push_back(vt[i].exp);
      if (vt[i].wr) wr(vt[i].wport, vt[i].wdata);
      else step(1);
      port_id = vt[i].rport;
      #1;
      v = data_out;
      check($sformatf("vec%0d", i), v, sbq.pop_front());
    end

    // 1: latency, ID readback, acknowledge and holdoff
    wr(MASK_P, 8'h0F);
    btn = 4'b0100;
    step(7);
    chk_intr("t1_lat7", 1'b0);
    step(1);
    chk_intr("t1_lat8", 1'b1);
    chk_rd("t1_id", ID_P, 8'h82);
    chk_rd("t1_stat_pre", STAT_P, 8'h04);
    pulse_inta();
    chk_rd("t1_stat_ack", STAT_P, 8'h00);
    chk_intr("t1_hold1", 1'b0);
    step(1);
    chk_intr("t1_hold2", 1'b0);
    step(4);
    chk_intr("t1_stay_low", 1'b0);
    btn = 4'b0000;
    step(10);
    chk_rd("t1_fall_ignored", STAT_P, 8'h00);

    // 2: bounce rejected, then one interrupt on stable level
    for (int i = 0; i < 10; i++) begin
      btn[0] = (i % 2 == 0);
      step(2);
      chk_rd($sformatf("t2_bounce%0d", i), STAT_P, 8'h00);
    end
    btn[0] = 1'b1;
    step(6);
    chk_rd("t2_stat6", STAT_P, 8'h00);
    step(1);
    chk_rd("t2_stat7", STAT_P, 8'h01);
    step(1);
    chk_intr("t2_intr", 1'b1);
    chk_rd("t2_id", ID_P, 8'h80);
    pulse_inta();
    step(10);
    chk_intr("t2_single", 1'b0);
    chk_rd("t2_stat_end", STAT_P, 8'h00);
    btn = 4'b0000;
    step(10);

    // 3: priority between simultaneous channels
    btn = 4'b1010;
    step(8);
    chk_intr("t3_intr1", 1'b1);
    chk_rd("t3_id1", ID_P, 8'h81);
    chk_rd("t3_stat1", STAT_P, 8'h0A);
    pulse_inta();
    chk_rd("t3_stat2", STAT_P, 8'h08);
    chk_intr("t3_hold1", 1'b0);
    step(1);
    chk_intr("t3_hold2", 1'b0);
    step(1);
    chk_intr("t3_idle", 1'b0);
    step(1);
    chk_intr("t3_intr2", 1'b1);
    chk_rd("t3_id2", ID_P, 8'h83);
    pulse_inta();
    btn = 4'b0000;
    step(10);
    chk_rd("t3_stat_end", STAT_P, 8'h00);

    // 4: masked pending, unmask, withdraw by clear
    wr(MASK_P, 8'h00);
    btn = 4'b0001;
    step(8);
    chk_rd("t4_stat", STAT_P, 8'h01);
    chk_intr("t4_masked", 1'b0);
    wr(MASK_P, 8'h01);
    chk_intr("t4_unmask0", 1'b0);
    step(1);
    chk_intr("t4_unmask1", 1'b1);
    chk_rd("t4_id", ID_P, 8'h80);
    wr(CLR_P, 8'h01);
    chk_rd("t4_clr_stat", STAT_P, 8'h00);
    step(1);
    chk_intr("t4_withdraw", 1'b0);
    chk_rd("t4_id_idle", ID_P, 8'h00);
    step(3);
    chk_intr("t4_stay", 1'b0);
    btn = 4'b0000;
    step(10);

    // 5: clear coinciding with set keeps the bit
    wr(MASK_P, 8'h00);
    btn = 4'b0100;
    step(6);
    chk_rd("t5_pre", STAT_P, 8'h00);
    wr(CLR_P, 8'h04);
    chk_rd("t5_collide", STAT_P, 8'h04);
    wr(CLR_P, 8'h04);
    chk_rd("t5_cleared", STAT_P, 8'h00);
    btn = 4'b0000;
    step(10);

    // 6: reset while asserted, then recovery with held input
    wr(MASK_P, 8'h02);
    btn = 4'b0010;
    step(8);
    chk_intr("t6_intr", 1'b1);
    chk_rd("t6_id", ID_P, 8'h81);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_intr("t6_rst_intr", 1'b0);
    chk_rd("t6_rst_mask", MASK_P, 8'h00);
    chk_rd("t6_rst_stat", STAT_P, 8'h00);
    wr(MASK_P, 8'h02);
    step(6);
    chk_intr("t6_lat7", 1'b0);
    step(1);
    chk_intr("t6_lat8", 1'b1);
    chk_rd("t6_id2", ID_P, 8'h81);
    pulse_inta();
    btn = 4'b0000;
    step(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
